// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared 64-bit memory bus between instruction fetch (IF) and the memory stage (DM).
// DM has fixed priority; a starvation counter forces an IF win, and a bus timeout returns an error completion.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [63:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic [1:0]  dm_size,
  output logic        dm_gnt,
  output logic        dm_done,
  output logic [63:0] dm_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [1:0]  bus_size,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata,
  output logic        err,
  output logic        err_src
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int ST_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [ST_W-1:0] starve_q, starve_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            owner_q, owner_d;      // 0 = IF, 1 = DM
  logic            if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic            if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [63:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [63:0]     bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [1:0]      bus_size_q, bus_size_d;
  logic            err_q, err_d, err_src_q, err_src_d;
  logic            if_wins;

  // IF only wins a contested cycle once DM has starved it STARVE_LIMIT times in a row.
  assign if_wins = if_req && (!dm_req || (starve_q == ST_MAX));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    starve_d    = starve_q;
    to_d        = to_q;
    owner_d     = owner_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    err_d       = 1'b0;
    err_src_d   = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_size_d  = bus_size_q;

    case (state_q)
      S_BUSY: begin
        to_d = to_q + TO_W'(1);
        if (bus_ack || (to_q == TO_LAST)) begin
          state_d     = S_DONE;
          to_d        = '0;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_size_d  = '0;
          err_d       = !bus_ack;
          err_src_d   = !bus_ack && owner_q;
          if (owner_q) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus_ack ? bus_rdata : '0;
          end
        end
      end
      default: begin
        // IDLE and DONE arbitrate identically, which allows back-to-back grants.
        state_d     = S_IDLE;
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_size_d  = '0;
        if (if_req || dm_req) begin
          state_d   = S_BUSY;
          to_d      = '0;
          bus_req_d = 1'b1;
          if (if_wins) begin
            owner_d    = 1'b0;
            if_gnt_d   = 1'b1;
            starve_d   = '0;
            bus_addr_d = if_addr;
            bus_size_d = 2'd3;
          end else begin
            owner_d     = 1'b1;
            dm_gnt_d    = 1'b1;
            bus_we_d    = dm_we;
            bus_addr_d  = dm_addr;
            bus_wdata_d = dm_wdata;
            bus_size_d  = dm_size;
            if (if_req && (starve_q != ST_MAX)) starve_d = starve_q + ST_W'(1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      to_q        <= '0;
      owner_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_size_q  <= '0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      to_q        <= to_d;
      owner_q     <= owner_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_size_q  <= bus_size_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_gnt    = dm_gnt_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_size  = bus_size_q;
  assign err       = err_q;
  assign err_src   = err_src_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed protocol steps followed by random
// transactions checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, bus_ack = 1'b0;
  logic [63:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, bus_rdata = '0;
  logic [1:0]  dm_size = '0;
  logic        if_gnt, if_done, dm_gnt, dm_done, bus_req, bus_we, err, err_src;
  logic [63:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic [1:0]  bus_size;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_size(bus_size), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .err(err), .err_src(err_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Reference-model state for the random phase.
  bit          if_pend, dm_pend, win_if, timed_out;
  int          starve, lat, n_wait;
  logic        exp_we;
  logic [1:0]  exp_size;
  logic [63:0] exp_addr, exp_wdata, exp_rdata, rd;

  initial begin
    // Reset held with both requests pending.
    if_req = 1'b1; dm_req = 1'b1; if_addr = 64'h40; dm_addr = 64'h80;
    tick(); tick(); tick();
    check("rst_bus_req", bus_req, 0);
    check("rst_gnts", {if_gnt, dm_gnt}, 0);
    check("rst_dones_err", {if_done, dm_done, err, err_src}, 0);
    check("rst_bus_addr", bus_addr, 0);
    reset = 1'b0;
    tick();
    check("rst_first_gnt", {if_gnt, dm_gnt}, 2'b01);
    if_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b1; bus_rdata = 64'h77;
    tick();
    bus_ack = 1'b0;
    check("rst_first_done", {if_done, dm_done}, 2'b01);

    // Single IF fetch, ack two cycles after bus_req rises.
    do_reset();
    if_req = 1'b1; if_addr = 64'h1000;
    tick();
    if_req = 1'b0;
    check("if_gnt", {if_gnt, dm_gnt, bus_req}, 3'b101);
    check("if_bus_addr", bus_addr, 64'h1000);
    check("if_bus_we_size", {bus_we, bus_size}, 3'b011);
    check("if_bus_wdata", bus_wdata, 0);
    tick();
    check("if_busy2", {bus_req, if_gnt, if_done}, 3'b100);
    tick();
    bus_ack = 1'b1; bus_rdata = 64'hDEAD;
    tick();
    bus_ack = 1'b0;
    check("if_done", {if_done, dm_done, err, bus_req}, 4'b1000);
    check("if_rdata", if_rdata, 64'hDEAD);
    tick();
    check("if_done_pulse", if_done, 0);

    // DM store: store completion returns zero data.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h2008; dm_wdata = 64'h55; dm_size = 2'd2;
    tick();
    dm_req = 1'b0;
    check("st_gnt", {if_gnt, dm_gnt, bus_req, bus_we}, 4'b0111);
    check("st_bus_addr", bus_addr, 64'h2008);
    check("st_bus_wdata", bus_wdata, 64'h55);
    check("st_bus_size", bus_size, 2);
    bus_ack = 1'b1; bus_rdata = 64'hFFFF;
    tick();
    bus_ack = 1'b0;
    check("st_done", {dm_done, if_done, err}, 3'b100);
    check("st_rdata", dm_rdata, 0);

    // Starvation: both held, immediate ack -> pattern DM x4, IF, repeat, back-to-back.
    do_reset();
    if_req = 1'b1; if_addr = 64'h3000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h4000; dm_size = 2'd3;
    for (int n = 0; n < 10; n++) begin
      tick();
      check($sformatf("starve_gnt%0d", n), {if_gnt, dm_gnt}, (n % 5 == 4) ? 2'b10 : 2'b01);
      bus_ack = 1'b1; bus_rdata = 64'(n + 100);
      tick();
      bus_ack = 1'b0;
      check($sformatf("starve_done%0d", n), {if_done, dm_done}, (n % 5 == 4) ? 2'b10 : 2'b01);
      check($sformatf("starve_rdata%0d", n), (n % 5 == 4) ? if_rdata : dm_rdata, 64'(n + 100));
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Timeout: no ack, error completion 8 cycles after bus_req rises.
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h5000;
    tick();
    dm_req = 1'b0;
    check("to_gnt", {dm_gnt, bus_req}, 2'b11);
    for (int c = 2; c <= TIMEOUT; c++) begin
      tick();
      check($sformatf("to_wait%0d", c), {bus_req, dm_done, err}, 3'b100);
    end
    tick();
    check("to_done", {dm_done, if_done, err, err_src, bus_req}, 5'b10110);
    check("to_rdata", dm_rdata, 0);
    tick();
    check("to_err_pulse", err, 0);

    // Ack on the final cycle wins over the timeout.
    dm_req = 1'b1;
    tick();
    dm_req = 1'b0;
    for (int c = 2; c <= TIMEOUT; c++) tick();
    check("to_ack_last_busy", {bus_req, dm_done}, 2'b10);
    bus_ack = 1'b1; bus_rdata = 64'h1234;
    tick();
    bus_ack = 1'b0;
    check("to_ack_last_done", {dm_done, err}, 2'b10);
    check("to_ack_last_rdata", dm_rdata, 64'h1234);

    // Reset in the middle of a bus cycle, then a stray ack.
    do_reset();
    if_req = 1'b1; if_addr = 64'h6000;
    tick();
    if_req = 1'b0;
    check("rmb_gnt", {if_gnt, bus_req}, 2'b11);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmb_bus_req", {bus_req, if_done, err}, 0);
    tick();
    bus_ack = 1'b1; bus_rdata = 64'h99;
    tick();
    bus_ack = 1'b0;
    check("rmb_late_ack", {if_done, dm_done, err, bus_req}, 0);

    // Random transactions against the transaction-level model.
    do_reset();
    if_pend = 0; dm_pend = 0; starve = 0;
    for (int t = 0; t < 80; t++) begin
      if (!if_pend && !dm_pend && $urandom_range(3) == 0) begin
        bus_ack = 1'($urandom_range(1));
        tick();
        bus_ack = 1'b0;
        check("rnd_idle", {bus_req, if_gnt, dm_gnt, if_done, dm_done, err}, 0);
      end
      if (!if_pend && $urandom_range(1) == 1) begin
        if_pend = 1; if_addr = {$urandom, $urandom};
      end
      if (!dm_pend && $urandom_range(1) == 1) begin
        dm_pend = 1; dm_we = 1'($urandom_range(1)); dm_addr = {$urandom, $urandom};
        dm_wdata = {$urandom, $urandom}; dm_size = 2'($urandom_range(3));
      end
      if (!if_pend && !dm_pend) begin
        if_pend = 1; if_addr = {$urandom, $urandom};
      end
      if_req = if_pend; dm_req = dm_pend;

      win_if = if_pend && (!dm_pend || starve == STARVE_LIMIT);
      if (win_if) starve = 0;
      else if (if_pend && starve < STARVE_LIMIT) starve++;
      exp_we    = win_if ? 1'b0 : dm_we;
      exp_addr  = win_if ? if_addr : dm_addr;
      exp_wdata = win_if ? 64'h0 : dm_wdata;
      exp_size  = win_if ? 2'd3 : dm_size;

      tick();
      check("rnd_gnt", {if_gnt, dm_gnt, bus_req}, {win_if, !win_if, 1'b1});
      check("rnd_bus_addr", bus_addr, exp_addr);
      check("rnd_bus_wdata", bus_wdata, exp_wdata);
      check("rnd_bus_we_size", {bus_we, bus_size}, {exp_we, exp_size});
      if (win_if) begin if_pend = 0; if_req = 1'b0; end
      else begin dm_pend = 0; dm_req = 1'b0; end

      lat = $urandom_range(0, 9);
      timed_out = (lat >= TIMEOUT);
      n_wait = timed_out ? TIMEOUT - 1 : lat;
      for (int c = 0; c < n_wait; c++) begin
        tick();
        check("rnd_busy", {bus_req, if_gnt, dm_gnt, if_done, dm_done}, 5'b10000);
        check("rnd_hold_addr", bus_addr, exp_addr);
      end
      rd = {$urandom, $urandom};
      if (!timed_out) begin bus_ack = 1'b1; bus_rdata = rd; end
      tick();
      bus_ack = 1'b0;
      exp_rdata = (timed_out || exp_we) ? 64'h0 : rd;
      check("rnd_done", {if_done, dm_done, err, bus_req}, {win_if, !win_if, timed_out, 1'b0});
      check("rnd_rdata", win_if ? if_rdata : dm_rdata, exp_rdata);
      check("rnd_bus_clear", bus_addr, 0);
      if (timed_out) check("rnd_err_src", err_src, !win_if);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
